// File: rtl/gb_ppu_pkg.sv
// ---------------------------------------------------------------------------
// gb_ppu_pkg : shared PPU fetcher types and VRAM layout constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gb_ppu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAP_A = 3'd1,
      MAP_D = 3'd2,
      LO_A  = 3'd3,
      LO_D  = 3'd4,
      HI_A  = 3'd5,
      HI_D  = 3'd6,
      PUSH  = 3'd7
   } fetch_state_e;

   localparam logic [12:0] MAP0_BASE             = 13'h1800;
   localparam logic [12:0] MAP1_BASE             = 13'h1C00;
   localparam logic [12:0] TILE_DATA_SIGNED_BASE = 13'h1000;
   localparam int          TILES_PER_LINE        = 21;

   // Address/data state pairs are the only states that drive the VRAM port.
   function automatic logic owns_vram(input fetch_state_e s);
      return (s != IDLE) && (s != PUSH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gb_bg_fetcher_if.sv
// ---------------------------------------------------------------------------
// gb_bg_fetcher_if : VRAM read port and pixel-row handshake of the BG fetcher
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gb_bg_fetcher_if;

   logic [12:0] vram_addr;
   logic        vram_rd;
   logic [7:0]  vram_q;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_lo;
   logic [7:0]  pix_hi;

   modport master (
      output vram_addr, vram_rd, pix_valid, pix_lo, pix_hi,
      input  vram_q, pix_ready
   );

   modport slave (
      input  vram_addr, vram_rd, pix_valid, pix_lo, pix_hi,
      output vram_q, pix_ready
   );

endinterface

`default_nettype wire

// File: rtl/gb_tile_addr.sv
// ---------------------------------------------------------------------------
// gb_tile_addr : combinational VRAM address for map / low / high plane reads
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gb_tile_addr
   import gb_ppu_pkg::*;
#(
   parameter logic [12:0] MAP0_BASE = gb_ppu_pkg::MAP0_BASE,
   parameter logic [12:0] MAP1_BASE = gb_ppu_pkg::MAP1_BASE
) (
   input  var  fetch_state_e i_state,
   input  wire logic [7:0]   i_y,
   input  wire logic [4:0]   i_scx_tile,
   input  wire logic [4:0]   i_n,
   input  wire logic [7:0]   i_idx,
   input  wire logic         i_bg_map_sel,
   input  wire logic         i_tile_data_sel,
   output logic [12:0]       o_addr
);

   logic [4:0]  col;
   logic [12:0] map_base;
   logic [12:0] map_addr;
   logic [12:0] data_base;
   logic [12:0] plane_addr;

   // 5-bit sum wraps column 31 back to 0 inside the same map row.
   assign col      = i_scx_tile + i_n;
   assign map_base = i_bg_map_sel ? MAP1_BASE : MAP0_BASE;
   assign map_addr = map_base + {3'b000, i_y[7:3], col};

   // Signed addressing: indices 0x00-0x7F live at 0x1000, 0x80-0xFF at 0x0800.
   assign data_base  = (~i_tile_data_sel & ~i_idx[7]) ? TILE_DATA_SIGNED_BASE : 13'h0000;
   assign plane_addr = data_base | {1'b0, i_idx, i_y[2:0], 1'b0};

   always_comb begin
      o_addr = 13'h0000;
      case (i_state)
         MAP_A, MAP_D: o_addr = map_addr;
         LO_A, LO_D:   o_addr = plane_addr;
         HI_A, HI_D:   o_addr = plane_addr | 13'h0001;
         default:      o_addr = 13'h0000;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/gb_bg_fetcher.sv
// ---------------------------------------------------------------------------
// gb_bg_fetcher : walks one scanline of BG tiles and streams 8-pixel rows
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gb_bg_fetcher
   import gb_ppu_pkg::*;
#(
   parameter int          TILES_PER_LINE = gb_ppu_pkg::TILES_PER_LINE,
   parameter logic [12:0] MAP0_BASE      = gb_ppu_pkg::MAP0_BASE,
   parameter logic [12:0] MAP1_BASE      = gb_ppu_pkg::MAP1_BASE
) (
   input  wire logic       clock,
   input  wire logic       reset,
   input  wire logic       start,
   input  wire logic [7:0] scx,
   input  wire logic [7:0] scy,
   input  wire logic [7:0] ly,
   input  wire logic       bg_map_sel,
   input  wire logic       tile_data_sel,
   gb_bg_fetcher_if.master bus,
   output logic            busy,
   output logic            done
);

   localparam logic [4:0] LAST_N = 5'(TILES_PER_LINE - 1);

   fetch_state_e state_q, state_d;
   logic [4:0]   n_q, n_d;
   logic [4:0]   scx_tile_q, scx_tile_d;
   logic [7:0]   y_q, y_d;
   logic         map_sel_q, map_sel_d;
   logic         data_sel_q, data_sel_d;
   logic [7:0]   idx_q, idx_d;
   logic [7:0]   pix_lo_q, pix_lo_d;
   logic [7:0]   pix_hi_q, pix_hi_d;
   logic         pix_valid_q, pix_valid_d;
   logic         vram_rd_q, vram_rd_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic         xfer;
   logic         last_tile;
   logic         unused_fine_scx;

   // Fine scroll is applied downstream by the pixel FIFO.
   assign unused_fine_scx = ^scx[2:0];

   assign xfer      = pix_valid_q & bus.pix_ready;
   assign last_tile = (n_q == LAST_N);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         n_q         <= '0;
         scx_tile_q  <= '0;
         y_q         <= '0;
         map_sel_q   <= 1'b0;
         data_sel_q  <= 1'b0;
         idx_q       <= '0;
         pix_lo_q    <= '0;
         pix_hi_q    <= '0;
         pix_valid_q <= 1'b0;
         vram_rd_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         scx_tile_q  <= scx_tile_d;
         y_q         <= y_d;
         map_sel_q   <= map_sel_d;
         data_sel_q  <= data_sel_d;
         idx_q       <= idx_d;
         pix_lo_q    <= pix_lo_d;
         pix_hi_q    <= pix_hi_d;
         pix_valid_q <= pix_valid_d;
         vram_rd_q   <= vram_rd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // start has priority everywhere: it also aborts a line in flight.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      scx_tile_d = scx_tile_q;
      y_d        = y_q;
      map_sel_d  = map_sel_q;
      data_sel_d = data_sel_q;
      idx_d      = idx_q;
      pix_lo_d   = pix_lo_q;
      pix_hi_d   = pix_hi_q;
      if (start) begin
         state_d    = MAP_A;
         n_d        = '0;
         scx_tile_d = scx[7:3];
         y_d        = ly + scy;
         map_sel_d  = bg_map_sel;
         data_sel_d = tile_data_sel;
      end else begin
         case (state_q)
            IDLE:  state_d = IDLE;
            MAP_A: state_d = MAP_D;
            MAP_D: begin
               state_d = LO_A;
               idx_d   = bus.vram_q;
            end
            LO_A:  state_d = LO_D;
            LO_D: begin
               state_d  = HI_A;
               pix_lo_d = bus.vram_q;
            end
            HI_A:  state_d = HI_D;
            HI_D: begin
               state_d  = PUSH;
               pix_hi_d = bus.vram_q;
            end
            PUSH: begin
               if (xfer) begin
                  if (last_tile) begin
                     state_d = IDLE;
                  end else begin
                     state_d = MAP_A;
                     n_d     = n_q + 5'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      vram_rd_d   = owns_vram(state_d);
      pix_valid_d = (state_d == PUSH);
      busy_d      = (state_d != IDLE);
      done_d      = !start && (state_q == PUSH) && xfer && last_tile;
   end

   gb_tile_addr #(
      .MAP0_BASE (MAP0_BASE),
      .MAP1_BASE (MAP1_BASE)
   ) u_tile_addr (
      .i_state         (state_q),
      .i_y             (y_q),
      .i_scx_tile      (scx_tile_q),
      .i_n             (n_q),
      .i_idx           (idx_q),
      .i_bg_map_sel    (map_sel_q),
      .i_tile_data_sel (data_sel_q),
      .o_addr          (bus.vram_addr)
   );

   assign bus.vram_rd   = vram_rd_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_lo    = pix_lo_q;
   assign bus.pix_hi    = pix_hi_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_gb_bg_fetcher.sv
// ---------------------------------------------------------------------------
// tb_gb_bg_fetcher : directed bench for the BG fetcher with a 1-cycle VRAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gb_bg_fetcher;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] scx;
   logic [7:0] scy;
   logic [7:0] ly;
   logic       bg_map_sel;
   logic       tile_data_sel;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [8192];

   gb_bg_fetcher_if bus();

   gb_bg_fetcher dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .scx           (scx),
      .scy           (scy),
      .ly            (ly),
      .bg_map_sel    (bg_map_sel),
      .tile_data_sel (tile_data_sel),
      .bus           (bus),
      .busy          (busy),
      .done          (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // VRAM: registered read, data valid the cycle after the address.
   always @(posedge clock) begin
      if (bus.vram_rd) bus.vram_q <= mem[bus.vram_addr];
   end

   task automatic step(input int k);
      repeat (k) @(negedge clock);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Called at a falling edge; returns at the falling edge of cycle 1.
   task automatic launch(input logic [7:0] s_scx, input logic [7:0] s_scy,
                         input logic [7:0] s_ly, input logic s_map, input logic s_data);
      scx = s_scx; scy = s_scy; ly = s_ly;
      bg_map_sel = s_map; tile_data_sel = s_data;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++; if (bus.vram_addr !== 13'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.vram_addr); end
      checks++; if (bus.vram_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", bus.vram_rd); end
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.pix_valid); end
      checks++; if (bus.pix_lo !== 8'h00) begin errors++; $display("FAIL reset_lo: got %h want 00", bus.pix_lo); end
      checks++; if (bus.pix_hi !== 8'h00) begin errors++; $display("FAIL reset_hi: got %h want 00", bus.pix_hi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge clock);
      reset = 1'b0;
      step(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      clear_mem();
      mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hAA; mem[13'h0051] = 8'h55;
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      checks++; if (bus.vram_addr !== 13'h1800) begin errors++; $display("FAIL basic_map_addr: got %h want 1800", bus.vram_addr); end
      checks++; if (bus.vram_rd !== 1'b1) begin errors++; $display("FAIL basic_map_rd: got %b want 1", bus.vram_rd); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      step(2);
      checks++; if (bus.vram_addr !== 13'h0050) begin errors++; $display("FAIL basic_lo_addr: got %h want 0050", bus.vram_addr); end
      step(2);
      checks++; if (bus.vram_addr !== 13'h0051) begin errors++; $display("FAIL basic_hi_addr: got %h want 0051", bus.vram_addr); end
      step(1);
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.pix_valid); end
      step(1);
      checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.pix_valid); end
      checks++; if (bus.pix_lo !== 8'hAA) begin errors++; $display("FAIL basic_lo: got %h want aa", bus.pix_lo); end
      checks++; if (bus.pix_hi !== 8'h55) begin errors++; $display("FAIL basic_hi: got %h want 55", bus.pix_hi); end
      checks++; if (bus.vram_rd !== 1'b0) begin errors++; $display("FAIL basic_push_rd: got %b want 0", bus.vram_rd); end
      step(1);
      checks++; if (bus.vram_addr !== 13'h1801) begin errors++; $display("FAIL basic_next_map: got %h want 1801", bus.vram_addr); end
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.pix_valid); end
   endtask

   task automatic test_signed();
      clear_mem();
      mem[13'h1800] = 8'h80; mem[13'h1801] = 8'h7F; mem[13'h1802] = 8'h00;
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      step(2);
      checks++; if (bus.vram_addr !== 13'h0800) begin errors++; $display("FAIL signed_80_lo: got %h want 0800", bus.vram_addr); end
      step(2);
      checks++; if (bus.vram_addr !== 13'h0801) begin errors++; $display("FAIL signed_80_hi: got %h want 0801", bus.vram_addr); end
      step(5);
      checks++; if (bus.vram_addr !== 13'h17F0) begin errors++; $display("FAIL signed_7f_lo: got %h want 17f0", bus.vram_addr); end
      step(7);
      checks++; if (bus.vram_addr !== 13'h1000) begin errors++; $display("FAIL signed_00_lo: got %h want 1000", bus.vram_addr); end
   endtask

   task automatic test_wrap();
      clear_mem();
      mem[13'h1C1F] = 8'h12;
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'hF8, 8'h04, 8'hFE, 1'b1, 1'b1);
      checks++; if (bus.vram_addr !== 13'h1C1F) begin errors++; $display("FAIL wrap_map0: got %h want 1c1f", bus.vram_addr); end
      step(2);
      checks++; if (bus.vram_addr !== 13'h0124) begin errors++; $display("FAIL wrap_lo_row: got %h want 0124", bus.vram_addr); end
      step(2);
      checks++; if (bus.vram_addr !== 13'h0125) begin errors++; $display("FAIL wrap_hi_row: got %h want 0125", bus.vram_addr); end
      step(3);
      checks++; if (bus.vram_addr !== 13'h1C00) begin errors++; $display("FAIL wrap_map1: got %h want 1c00", bus.vram_addr); end
      step(2);
      checks++; if (bus.vram_addr !== 13'h0004) begin errors++; $display("FAIL wrap_lo_tile1: got %h want 0004", bus.vram_addr); end
   endtask

   task automatic test_backpressure();
      clear_mem();
      mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hAA; mem[13'h0051] = 8'h55;
      do_reset();
      bus.pix_ready = 1'b0;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      step(6);
      for (int k = 0; k < 6; k++) begin
         checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus.pix_valid); end
         checks++; if (bus.pix_lo !== 8'hAA || bus.pix_hi !== 8'h55) begin errors++; $display("FAIL bp_data[%0d]: got %h/%h want aa/55", k, bus.pix_lo, bus.pix_hi); end
         checks++; if (bus.vram_rd !== 1'b0) begin errors++; $display("FAIL bp_rd[%0d]: got %b want 0", k, bus.vram_rd); end
         if (k < 5) step(1);
      end
      bus.pix_ready = 1'b1;
      step(1);
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid: got %b want 0", bus.pix_valid); end
      checks++; if (bus.vram_addr !== 13'h1801 || bus.vram_rd !== 1'b1) begin errors++; $display("FAIL bp_after_map: got %h rd %b want 1801 rd 1", bus.vram_addr, bus.vram_rd); end
   endtask

   task automatic test_full_line();
      int xfers = 0;
      int done_cnt = 0;
      int done_cyc = 0;
      clear_mem();
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int c = 1; c <= 150; c++) begin
         if (bus.pix_valid && bus.pix_ready) xfers++;
         if (done) begin done_cnt++; done_cyc = c; end
         if (c == 147) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL line_busy_147: got %b want 1", busy); end
         end
         step(1);
      end
      checks++; if (xfers != 21) begin errors++; $display("FAIL line_xfers: got %0d want 21", xfers); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL line_done_count: got %0d want 1", done_cnt); end
      checks++; if (done_cyc != 148) begin errors++; $display("FAIL line_done_cycle: got %0d want 148", done_cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL line_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_start_on_last();
      clear_mem();
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      step(146);
      checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL last_push_valid: got %b want 1", bus.pix_valid); end
      scx = 8'h10;
      start = 1'b1;
      step(1);
      start = 1'b0;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL last_start_done: got %b want 0", done); end
      checks++; if (bus.vram_addr !== 13'h1802) begin errors++; $display("FAIL last_start_map: got %h want 1802", bus.vram_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL last_start_busy: got %b want 1", busy); end
   endtask

   task automatic test_abort();
      int done_cnt = 0;
      int done_at = 0;
      clear_mem();
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      step(33);
      bus.pix_ready = 1'b0;
      step(1);
      checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b want 1", bus.pix_valid); end
      scx = 8'h08;
      start = 1'b1;
      step(1);
      start = 1'b0;
      bus.pix_ready = 1'b1;
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_drop: got %b want 0", bus.pix_valid); end
      checks++; if (bus.vram_addr !== 13'h1801 || bus.vram_rd !== 1'b1) begin errors++; $display("FAIL abort_restart_map: got %h rd %b want 1801 rd 1", bus.vram_addr, bus.vram_rd); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
      for (int k = 2; k <= 148; k++) begin
         step(1);
         if (done) begin done_cnt++; done_at = k; end
      end
      checks++; if (done_cnt != 1 || done_at != 148) begin errors++; $display("FAIL abort_new_done: count %0d at %0d want 1 at 148", done_cnt, done_at); end
   endtask

   task automatic test_async_reset();
      clear_mem();
      mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hAA; mem[13'h0051] = 8'h55;
      do_reset();
      bus.pix_ready = 1'b1;
      launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      step(5);
      checks++; if (bus.pix_lo !== 8'hAA || bus.vram_addr !== 13'h0051) begin errors++; $display("FAIL ar_pre: lo %h addr %h want aa 0051", bus.pix_lo, bus.vram_addr); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.vram_addr !== 13'h0000) begin errors++; $display("FAIL ar_addr: got %h want 0000", bus.vram_addr); end
      checks++; if (bus.vram_rd !== 1'b0) begin errors++; $display("FAIL ar_rd: got %b want 0", bus.vram_rd); end
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.pix_valid); end
      checks++; if (bus.pix_lo !== 8'h00) begin errors++; $display("FAIL ar_lo: got %h want 00", bus.pix_lo); end
      checks++; if (bus.pix_hi !== 8'h00) begin errors++; $display("FAIL ar_hi: got %h want 00", bus.pix_hi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL ar_done: got %b want 0", done); end
      @(negedge clock);
      reset = 1'b0;
      step(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_after_busy: got %b want 0", busy); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      scx = 8'h00; scy = 8'h00; ly = 8'h00;
      bg_map_sel = 1'b0; tile_data_sel = 1'b1;
      bus.pix_ready = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_wrap();
      test_backpressure();
      test_full_line();
      test_start_on_last();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
